draw_player: RTL and testbench
==============================

DRAW_PLAYER -- requirements
Module: draw_player

Interface
REQ-001 Parameter TOP_V_LINE, 367, top inner edge of game area (px).
REQ-002 Parameter BOTTOM_V_LINE, 667, bottom inner edge (exclusive).
REQ-003 Parameter LEFT_H_LINE, 361, left inner edge.
REQ-004 Parameter RIGHT_H_LINE, 661, right inner edge (exclusive).
REQ-005 Parameter PLAYER_SIZE, 20, square side (px).
REQ-006 Parameter STEP, 2, movement per frame (px).
REQ-007 Parameter HIT_FRAMES, 64, invulnerability length (frames).
REQ-008 Parameter PLAYER_COLOR, 12'h0_f_0, player colour.
REQ-009 pclk  in  1  pixel clock; single clock domain, all logic on rising edge.
REQ-010 rst  in  1  reset, synchronous, active-high.
REQ-011 hcount_in/vcount_in  in  12 each  pixel position from the background stage.
REQ-012 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing from the background stage.
REQ-013 rgb_in  in  12  background colour.
REQ-014 up_in, down_in, left_in, right_in  in  1 each  level direction requests.
REQ-015 hit_in  in  1  single-cycle collision pulse.
REQ-016 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  12/12/1/1/1/1  timing delayed one cycle.
REQ-017 rgb_out  out  12  composited colour; lives_out  out  2  remaining lives; dead_out  out  1  game-over flag.

Function
REQ-018 All outputs SHALL be registered with exactly 1 pclk latency from the matching inputs.
REQ-019 frame_tick SHALL be asserted for one cycle when vblnk_in is 1 and was 0 the previous cycle.
REQ-020 Player position (x,y) = top-left corner, 12 bits each, updated only on frame_tick.
REQ-021 On frame_tick: x += STEP if right_in & !left_in; x -= STEP if left_in & !right_in; both or neither -> unchanged; y likewise with down_in(+)/up_in(-).
REQ-022 Updated x SHALL be clamped to [LEFT_H_LINE, RIGHT_H_LINE-PLAYER_SIZE], y to [TOP_V_LINE, BOTTOM_V_LINE-PLAYER_SIZE]; subtraction SHALL not underflow (compare before subtract).
REQ-023 FSM states ALIVE, HIT, DEAD; ALIVE -> HIT on hit_in with lives>1 (lives decremented, frame counter cleared); ALIVE -> DEAD on hit_in with lives==1 (lives=0).
REQ-024 In HIT, frame counter SHALL increment per frame_tick; at HIT_FRAMES ticks -> ALIVE; hit_in SHALL be ignored in HIT.
REQ-025 DEAD SHALL be terminal until rst; position frozen, hit_in ignored, dead_out=1.
REQ-026 hit_in coincident with frame_tick: movement and the hit transition SHALL both take effect in the same cycle.
REQ-027 Player visible when ALIVE, or HIT with frame counter bit 3 == 0 (8-frame blink); never in DEAD.
REQ-028 rgb_nxt = PLAYER_COLOR when visible, hblnk_in=0, vblnk_in=0, x<=hcount_in<x+PLAYER_SIZE and y<=vcount_in<y+PLAYER_SIZE; else rgb_in.
REQ-029 Timing signals SHALL pass through unmodified.

Reset
REQ-030 On rst: all timing outputs and rgb_out 0; x=501, y=507 (area centre); state ALIVE; lives_out=3; dead_out=0; frame counter 0; vblnk history 0.
REQ-031 rst mid-frame or mid-HIT SHALL take effect on the next edge with no residual state.

Structure
REQ-032 Game-area bounds, PLAYER_COLOR and FSM state encoding SHALL live in the shared game package/header used by draw_background.
REQ-033 Position and FSM logic SHALL be one sub-module player_ctl (outputs x, y, visible, lives, dead); compositing and output registers in draw_player.

Verification
REQ-034 After rst, frame with no inputs -> square at hcount 501..520, vcount 507..526 is 12'h0_f_0, rgb_in elsewhere, 1-cycle latency.
REQ-035 right_in held 200 frames -> x increments by 2 per frame, saturates at 641, never exceeds.
REQ-036 left_in & right_in & up_in held 10 frames -> x stays 501, y = 487.
REQ-037 hit_in pulse -> lives_out=2, square blinks (absent frames 8-15, 24-31, ...), ALIVE after 64 frames; second hit_in during HIT ignored.
REQ-038 Three hits spaced >64 frames -> lives_out=0, dead_out=1, rgb_out==rgb_in, movement ignored until rst.
REQ-039 rst asserted during HIT blink -> next cycle lives_out=3, position 501/507, outputs 0.

Source files
------------

// File: rtl/draw_player_pkg.sv
// Shared game constants: play-area bounds, player colour and player FSM encoding.
// Also used by draw_background, so both stages agree on the same geometry.
package draw_player_pkg;

    localparam int GAME_TOP_V_LINE    = 367;
    localparam int GAME_BOTTOM_V_LINE = 667;
    localparam int GAME_LEFT_H_LINE   = 361;
    localparam int GAME_RIGHT_H_LINE  = 661;
    localparam int GAME_PLAYER_SIZE   = 20;

    localparam logic [11:0] GAME_PLAYER_COLOR = 12'h0_f_0;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_HIT   = 2'd1,
        ST_DEAD  = 2'd2
    } player_state_e;

endpackage

// File: rtl/player_ctl.sv
// Player position and life FSM, advanced once per frame on the rising edge of vblank.
// Latency: state updates on the edge after the input; no backpressure.
module player_ctl
    import draw_player_pkg::*;
#(
    parameter int TOP_V_LINE    = GAME_TOP_V_LINE,
    parameter int BOTTOM_V_LINE = GAME_BOTTOM_V_LINE,
    parameter int LEFT_H_LINE   = GAME_LEFT_H_LINE,
    parameter int RIGHT_H_LINE  = GAME_RIGHT_H_LINE,
    parameter int PLAYER_SIZE   = GAME_PLAYER_SIZE,
    parameter int STEP          = 2,
    parameter int HIT_FRAMES    = 64
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_i,
    input  logic        up_i,
    input  logic        down_i,
    input  logic        left_i,
    input  logic        right_i,
    input  logic        hit_i,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        visible_o,
    output logic [1:0]  lives_o,
    output logic        dead_o
);

    localparam int CW = $clog2(HIT_FRAMES) + 1;

    localparam logic [11:0] X_MIN   = 12'(LEFT_H_LINE);
    localparam logic [11:0] X_MAX   = 12'(RIGHT_H_LINE - PLAYER_SIZE);
    localparam logic [11:0] Y_MIN   = 12'(TOP_V_LINE);
    localparam logic [11:0] Y_MAX   = 12'(BOTTOM_V_LINE - PLAYER_SIZE);
    localparam logic [11:0] STP     = 12'(STEP);
    localparam logic [11:0] X_START = 12'((LEFT_H_LINE + RIGHT_H_LINE) / 2 - PLAYER_SIZE / 2);
    localparam logic [11:0] Y_START = 12'((TOP_V_LINE + BOTTOM_V_LINE) / 2 - PLAYER_SIZE / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(HIT_FRAMES - 1);

    player_state_e state_q, state_d;
    logic [11:0]   x_q, x_d, y_q, y_d;
    logic [1:0]    lives_q, lives_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vblnk_q;
    logic          frame_tick;

    // Limits are checked before the add/subtract so the position never wraps.
    function automatic logic [11:0] step_axis(input logic [11:0] pos, input logic inc,
                                              input logic dec, input logic [11:0] lo,
                                              input logic [11:0] hi);
        logic [11:0] res;
        res = pos;
        if (inc && !dec) begin
            res = (pos >= hi - STP) ? hi : pos + STP;
        end else if (dec && !inc) begin
            res = (pos <= lo + STP) ? lo : pos - STP;
        end
        return res;
    endfunction

    assign frame_tick = vblnk_i & ~vblnk_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;

        if (frame_tick && state_q != ST_DEAD) begin
            x_d = step_axis(x_q, right_i, left_i, X_MIN, X_MAX);
            y_d = step_axis(y_q, down_i, up_i, Y_MIN, Y_MAX);
        end

        unique case (state_q)
            ST_ALIVE: begin
                if (hit_i) begin
                    if (lives_q > 2'd1) begin
                        state_d = ST_HIT;
                        lives_d = lives_q - 2'd1;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_DEAD;
                        lives_d = 2'd0;
                    end
                end
            end
            ST_HIT: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_ALIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DEAD: begin
            end
            default: state_d = ST_DEAD;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= ST_ALIVE;
            x_q     <= X_START;
            y_q     <= Y_START;
            lives_q <= 2'd3;
            cnt_q   <= '0;
            vblnk_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            vblnk_q <= vblnk_i;
        end
    end

    // Bit 3 of the invulnerability count gives an 8-frame on/off blink.
    assign visible_o = (state_q == ST_ALIVE) || (state_q == ST_HIT && !cnt_q[3]);
    assign x_o       = x_q;
    assign y_o       = y_q;
    assign lives_o   = lives_q;
    assign dead_o    = (state_q == ST_DEAD);

endmodule

// File: rtl/draw_player.sv
// Overlays the player square on the background stream and forwards timing unchanged.
// Latency: 1 pclk on every output; no backpressure (free-running pixel pipeline).
module draw_player
    import draw_player_pkg::*;
#(
    parameter int          TOP_V_LINE    = GAME_TOP_V_LINE,
    parameter int          BOTTOM_V_LINE = GAME_BOTTOM_V_LINE,
    parameter int          LEFT_H_LINE   = GAME_LEFT_H_LINE,
    parameter int          RIGHT_H_LINE  = GAME_RIGHT_H_LINE,
    parameter int          PLAYER_SIZE   = GAME_PLAYER_SIZE,
    parameter int          STEP          = 2,
    parameter int          HIT_FRAMES    = 64,
    parameter logic [11:0] PLAYER_COLOR  = GAME_PLAYER_COLOR
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        up_in,
    input  logic        down_in,
    input  logic        left_in,
    input  logic        right_in,
    input  logic        hit_in,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [1:0]  lives_out,
    output logic        dead_out
);

    logic [11:0] player_x, player_y;
    logic        player_visible;
    logic        in_box;
    logic [11:0] rgb_nxt;

    player_ctl #(
        .TOP_V_LINE   (TOP_V_LINE),
        .BOTTOM_V_LINE(BOTTOM_V_LINE),
        .LEFT_H_LINE  (LEFT_H_LINE),
        .RIGHT_H_LINE (RIGHT_H_LINE),
        .PLAYER_SIZE  (PLAYER_SIZE),
        .STEP         (STEP),
        .HIT_FRAMES   (HIT_FRAMES)
    ) u_ctl (
        .pclk     (pclk),
        .rst      (rst),
        .vblnk_i  (vblnk_in),
        .up_i     (up_in),
        .down_i   (down_in),
        .left_i   (left_in),
        .right_i  (right_in),
        .hit_i    (hit_in),
        .x_o      (player_x),
        .y_o      (player_y),
        .visible_o(player_visible),
        .lives_o  (lives_out),
        .dead_o   (dead_out)
    );

    always_comb begin
        in_box = (hcount_in >= player_x) && (hcount_in < player_x + 12'(PLAYER_SIZE)) &&
                 (vcount_in >= player_y) && (vcount_in < player_y + 12'(PLAYER_SIZE));
        rgb_nxt = rgb_in;
        if (player_visible && !hblnk_in && !vblnk_in && in_box) begin
            rgb_nxt = PLAYER_COLOR;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            hblnk_out  <= hblnk_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= rgb_nxt;
        end
    end

endmodule

// File: tb/tb_draw_player.sv
// Randomised frames checked every cycle against a frame-level player model, plus literal probes.
module tb_draw_player;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] hcount_in, vcount_in, rgb_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic        up_in, down_in, left_in, right_in, hit_in;
    logic [11:0] hcount_out, vcount_out, rgb_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [1:0]  lives_out;
    logic        dead_out;

    int total = 0;
    int bad   = 0;

    draw_player dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .up_in(up_in), .down_in(down_in), .left_in(left_in), .right_in(right_in),
        .hit_in(hit_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .lives_out(lives_out), .dead_out(dead_out)
    );

    always #5 pclk = ~pclk;

    // Model: position, lives, and frames of invulnerability still to run.
    int   m_x, m_y, m_lives, m_hit_left;
    bit   m_dead, m_vprev;
    bit   model_valid = 0;
    logic [42:0] exp_vec;

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    always @(posedge pclk) begin
        bit vis, inbox, tick;
        logic [11:0] e_rgb;
        int dx, dy;
        if (rst) begin
            m_x = 501; m_y = 507; m_lives = 3; m_hit_left = 0; m_dead = 0; m_vprev = 0;
            exp_vec = {12'd0, 12'd0, 4'd0, 12'd0, 2'd3, 1'b0};
        end else begin
            vis = !m_dead && (m_hit_left == 0 || (((64 - m_hit_left) / 8) % 2) == 0);
            inbox = int'(hcount_in) >= m_x && int'(hcount_in) < m_x + 20 &&
                    int'(vcount_in) >= m_y && int'(vcount_in) < m_y + 20;
            e_rgb = (vis && inbox && !hblnk_in && !vblnk_in) ? 12'h0f0 : rgb_in;
            tick = vblnk_in && !m_vprev;
            m_vprev = vblnk_in;
            if (!m_dead) begin
                if (tick) begin
                    dx = (right_in && !left_in) ? 2 : ((left_in && !right_in) ? -2 : 0);
                    dy = (down_in && !up_in) ? 2 : ((up_in && !down_in) ? -2 : 0);
                    m_x = clampi(m_x + dx, 361, 641);
                    m_y = clampi(m_y + dy, 367, 647);
                end
                if (m_hit_left > 0) begin
                    if (tick) m_hit_left--;
                end else if (hit_in) begin
                    m_lives--;
                    if (m_lives == 0) m_dead = 1;
                    else m_hit_left = 64;
                end
            end
            exp_vec = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
                       e_rgb, 2'(m_lives), m_dead};
        end
        model_valid = 1;
    end

    always @(negedge pclk) begin
        logic [42:0] act;
        if (model_valid) begin
            act = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                   rgb_out, lives_out, dead_out};
            total++;
            if (act !== exp_vec) begin
                bad++;
                $display("FAIL cycle_compare t=%0t got h=%0d v=%0d sync/blnk=%b rgb=%h lives=%0d dead=%b want h=%0d v=%0d sync/blnk=%b rgb=%h lives=%0d dead=%b",
                         $time, act[42:31], act[30:19], act[18:15], act[14:3], act[2:1], act[0],
                         exp_vec[42:31], exp_vec[30:19], exp_vec[18:15], exp_vec[14:3],
                         exp_vec[2:1], exp_vec[0]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s got %0d want %0d", name, act, expv);
        end
    endtask

    task automatic idle_cycle();
        hit_in = 0; vblnk_in = 0; hblnk_in = 1;
        hcount_in = 12'($urandom_range(0, 1023)); vcount_in = 12'($urandom_range(0, 1023));
        rgb_in = 12'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
        @(negedge pclk);
    endtask

    // One active pixel at (h,v); want_player selects the literal colour or the background.
    task automatic probe(input string name, input int h, input int v, input bit want_player);
        logic [11:0] bg;
        hit_in = 0; vblnk_in = 0; hblnk_in = 0;
        hcount_in = 12'(h); vcount_in = 12'(v);
        bg = 12'($urandom_range(0, 12'hfff));
        if (bg == 12'h0f0) bg = 12'h00f;
        rgb_in = bg;
        @(negedge pclk);
        chk(name, int'(rgb_out), want_player ? 32'h0f0 : int'(bg));
    endtask

    task automatic do_reset();
        rst = 1;
        idle_cycle();
        idle_cycle();
        rst = 0;
    endtask

    // hit_at: -1 none, 0 on the vblank edge cycle, k>0 on active cycle k.
    task automatic frame(input int nact, input bit u, input bit d, input bit l, input bit r,
                         input int hit_at);
        up_in = u; down_in = d; left_in = l; right_in = r;
        for (int c = 0; c < 2; c++) begin
            vblnk_in = 1; hblnk_in = 1'($urandom);
            hit_in = (hit_at == 0 && c == 0);
            hcount_in = 12'($urandom_range(0, 1023)); vcount_in = 12'($urandom_range(0, 1023));
            rgb_in = 12'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            @(negedge pclk);
        end
        for (int i = 1; i <= nact; i++) begin
            vblnk_in = 0; hblnk_in = ($urandom_range(0, 7) == 0);
            hit_in = (hit_at == i);
            hcount_in = 12'(m_x - 3 + int'($urandom_range(0, 25)));
            vcount_in = 12'(m_y - 3 + int'($urandom_range(0, 25)));
            rgb_in = 12'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            @(negedge pclk);
        end
        hit_in = 0;
    endtask

    task automatic frames(input int n, input bit u, input bit d, input bit l, input bit r);
        for (int k = 0; k < n; k++) frame(int'($urandom_range(3, 8)), u, d, l, r, -1);
    endtask

    initial begin
        int nact, hat;
        rst = 1; up_in = 0; down_in = 0; left_in = 0; right_in = 0;
        hit_in = 0; vblnk_in = 0; hblnk_in = 1;
        hcount_in = 0; vcount_in = 0; rgb_in = 0; hsync_in = 0; vsync_in = 0;
        @(negedge pclk);
        do_reset();

        // Idle frame after reset: square at 501..520 x 507..526.
        frames(1, 0, 0, 0, 0);
        probe("rst_tl", 501, 507, 1);
        probe("rst_br", 520, 526, 1);
        probe("rst_right_edge", 521, 507, 0);
        probe("rst_left_edge", 500, 507, 0);
        probe("rst_bottom_edge", 501, 527, 0);

        // Hold right: saturates at 641.
        frames(200, 0, 0, 0, 1);
        chk("x_saturate", m_x, 641);
        probe("sat_left_in", 641, 507, 1);
        probe("sat_left_out", 640, 507, 0);
        probe("sat_right_in", 660, 526, 1);
        probe("sat_right_out", 661, 507, 0);

        // Left+right cancel, up moves 10 frames.
        do_reset();
        frames(10, 1, 0, 1, 1);
        chk("cancel_x", m_x, 501);
        chk("up_y", m_y, 487);
        probe("up_top_in", 501, 487, 1);
        probe("up_top_out", 501, 486, 0);
        probe("up_bottom_in", 501, 506, 1);
        probe("up_bottom_out", 501, 507, 0);

        // Hit, blink pattern, ignored second hit, recovery after 64 frames.
        do_reset();
        frame(5, 0, 0, 0, 0, 3);
        chk("hit_lives", int'(lives_out), 2);
        frames(7, 0, 0, 0, 0);
        probe("blink_on_7", 501, 507, 1);
        frames(1, 0, 0, 0, 0);
        probe("blink_off_8", 501, 507, 0);
        frame(5, 0, 0, 0, 0, 2);
        chk("hit_ignored_lives", int'(lives_out), 2);
        frames(54, 0, 0, 0, 0);
        probe("blink_off_63", 501, 507, 0);
        frames(1, 0, 0, 0, 0);
        probe("alive_again", 501, 507, 1);
        chk("alive_not_dead", int'(dead_out), 0);

        // Three spaced hits -> dead, movement frozen.
        do_reset();
        frame(5, 0, 0, 0, 0, 2);
        frames(70, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        frame(5, 0, 0, 0, 0, 0);
        frames(70, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        frame(5, 0, 0, 0, 0, 4);
        chk("dead_lives", int'(lives_out), 0);
        chk("dead_flag", int'(dead_out), 1);
        frames(5, 0, 0, 0, 1);
        probe("dead_invisible", m_x, m_y, 0);
        chk("dead_sticky", int'(dead_out), 1);

        // Reset in the middle of a blink.
        do_reset();
        frame(5, 0, 0, 0, 0, 1);
        frames(12, 0, 1, 1, 0);
        rst = 1;
        vblnk_in = 0; hblnk_in = 0; hcount_in = 12'd505; vcount_in = 12'd510; rgb_in = 12'h123;
        @(negedge pclk);
        chk("midhit_rst_lives", int'(lives_out), 3);
        chk("midhit_rst_rgb", int'(rgb_out), 0);
        chk("midhit_rst_hcount", int'(hcount_out), 0);
        rst = 0;
        probe("midhit_rst_pos", 501, 507, 1);

        // Random play, including hits on the vblank edge and occasional resets.
        for (int f = 0; f < 300; f++) begin
            nact = int'($urandom_range(3, 12));
            hat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nact)) : -1;
            if ($urandom_range(0, 59) == 0) do_reset();
            frame(nact, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), hat);
        end

        idle_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
